// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file.
//   rf_state_t    : controller state (init walk vs. accepting traffic)
//   RF_N_REGS     : default number of architectural registers
//   RF_DATA_WIDTH : default register width in bits
package regfile_pkg;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_t;

    localparam int RF_N_REGS     = 32;
    localparam int RF_DATA_WIDTH = 32;

endpackage : regfile_pkg

// File: rtl/regfile_mp_sb_if.sv
// Bundle of all non-clock/reset signals of the register file.
//   master : issue/writeback side (drives writes, reads, scoreboard sets)
//   slave  : the register file itself
// Signals:
//   ready      : init walk finished, traffic accepted
//   we         : per-write-port enable
//   wAddrs     : per-write-port address
//   wPorts     : per-write-port data
//   rAddrs     : per-read-port address
//   rPorts     : per-read-port data (combinational)
//   rBusy      : per-read-port pending-write flag
//   issueValid : mark issueAddr as pending
//   issueAddr  : destination register being issued
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int N_REGS        = RF_N_REGS,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int N_READ_PORTS  = 2,
    parameter int N_WRITE_PORTS = 2,
    parameter int ADDR_WIDTH    = $clog2(N_REGS)
);

    logic                                       ready;
    logic [N_WRITE_PORTS-1:0]                   we;
    logic [N_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   wAddrs;
    logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wPorts;
    logic [N_READ_PORTS-1:0][ADDR_WIDTH-1:0]    rAddrs;
    logic [N_READ_PORTS-1:0][DATA_WIDTH-1:0]    rPorts;
    logic [N_READ_PORTS-1:0]                    rBusy;
    logic                                       issueValid;
    logic [ADDR_WIDTH-1:0]                      issueAddr;

    modport master (
        input  ready, rPorts, rBusy,
        output we, wAddrs, wPorts, rAddrs, issueValid, issueAddr
    );

    modport slave (
        output ready, rPorts, rBusy,
        input  we, wAddrs, wPorts, rAddrs, issueValid, issueAddr
    );

endinterface : regfile_mp_sb_if

// File: rtl/regfile_fwd_mux.sv
// Read-port select for one read port of the register file.
// Priority: forced zero (inactive, zero register, out-of-range address),
// then same-cycle write forwarding (highest write port wins), then the
// stored array value. The busy flag is masked when the read is forwarded.
// Ports:
//   active_i   : file is in the ready state
//   rd_addr_i  : read address
//   wr_en_i    : qualified (non-suppressed) write enables
//   wr_addr_i  : write addresses
//   wr_data_i  : write data
//   arr_data_i : stored value at rd_addr_i
//   busy_i     : scoreboard bit at rd_addr_i
//   rd_data_o  : selected read data
//   rd_busy_o  : pending-write flag seen by this port
module regfile_fwd_mux #(
    parameter int N_REGS        = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int N_WRITE_PORTS = 2,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic                                     active_i,
    input  logic [ADDR_WIDTH-1:0]                    rd_addr_i,
    input  logic [N_WRITE_PORTS-1:0]                 wr_en_i,
    input  logic [N_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data_i,
    input  logic [DATA_WIDTH-1:0]                    arr_data_i,
    input  logic                                     busy_i,
    output logic [DATA_WIDTH-1:0]                    rd_data_o,
    output logic                                     rd_busy_o
);

    logic                  zero_hit;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign zero_hit = !active_i
                   || ((ZERO_REG != 0) && (rd_addr_i == '0))
                   || !(32'(rd_addr_i) < N_REGS);

    // Ascending scan: a later (higher-index) match overrides an earlier one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path leaves it unassigned and a latch is never inferred.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < N_WRITE_PORTS; i++) begin
            if (wr_en_i[i] && (wr_addr_i[i] == rd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data_i[i];
            end
        end
    end

    always_comb begin
        rd_data_o = arr_data_i;
        rd_busy_o = busy_i;
        if (zero_hit) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else if ((BYPASS != 0) && fwd_hit) begin
            rd_data_o = fwd_data;
            rd_busy_o = 1'b0;
        end
    end

endmodule : regfile_fwd_mux

// File: rtl/regfile_mp_sb.sv
// Multi-ported register file with per-register pending-write scoreboard.
// After reset the storage is cleared by a one-register-per-cycle walk; the
// file reports ready once every register has been zeroed.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, restarts the init walk
//   bus : regfile_mp_sb_if slave (writes, reads, scoreboard set, ready)
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int N_REGS        = RF_N_REGS,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int N_READ_PORTS  = 2,
    parameter int N_WRITE_PORTS = 2,
    parameter int ADDR_WIDTH    = $clog2(N_REGS),
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mp_sb_if.slave  bus
);

    rf_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  init_cnt_q, init_cnt_d;
    logic [N_REGS-1:0]      busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  regs_q [N_REGS];

    logic [N_WRITE_PORTS-1:0] wr_ok;
    logic                     issue_ok;
    logic                     active;

    logic [N_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [N_READ_PORTS-1:0]                 rd_busy;

    // Addresses that may be written or marked pending.
    function automatic logic addr_writable(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < N_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign active    = (state_q == RF_READY);
    assign bus.ready = active;

    // Qualified write and issue strobes; traffic is ignored during init.
    always_comb begin
        for (int i = 0; i < N_WRITE_PORTS; i++) begin
            wr_ok[i] = active && bus.we[i] && addr_writable(bus.wAddrs[i]);
        end
    end

    assign issue_ok = active && bus.issueValid && addr_writable(bus.issueAddr);

    // Init walk sequencing.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == RF_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_WIDTH'(N_REGS - 1)) begin
                state_d = RF_READY;
            end
        end
    end

    // Scoreboard: clears from writeback first, then the issue set, so a set
    // and clear of the same register in one cycle leaves it pending.
    always_comb begin
        // NOTE: blocking assignments in combinational logic so the later
        // statement (the set) overrides the earlier one (the clear).
        busy_d = busy_q;
        for (int i = 0; i < N_WRITE_PORTS; i++) begin
            if (wr_ok[i]) begin
                busy_d[bus.wAddrs[i]] = 1'b0;
            end
        end
        if (issue_ok) begin
            busy_d[bus.issueAddr] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RF_INIT;
            init_cnt_q <= '0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // NOTE: the storage array has no reset term; it is cleared by the init
    // walk, which keeps reset off the wide data array. Higher write ports
    // are assigned later in the loop, so they win on an address conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_INIT) begin
                regs_q[init_cnt_q] <= '0;
            end else begin
                for (int i = 0; i < N_WRITE_PORTS; i++) begin
                    if (wr_ok[i]) begin
                        regs_q[bus.wAddrs[i]] <= bus.wPorts[i];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < N_READ_PORTS; j++) begin : g_rd
        regfile_fwd_mux #(
            .N_REGS        (N_REGS),
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDR_WIDTH    (ADDR_WIDTH),
            .N_WRITE_PORTS (N_WRITE_PORTS),
            .BYPASS        (BYPASS),
            .ZERO_REG      (ZERO_REG)
        ) u_fwd_mux (
            .active_i   (active),
            .rd_addr_i  (bus.rAddrs[j]),
            .wr_en_i    (wr_ok),
            .wr_addr_i  (bus.wAddrs),
            .wr_data_i  (bus.wPorts),
            .arr_data_i (regs_q[bus.rAddrs[j]]),
            .busy_i     (busy_q[bus.rAddrs[j]]),
            .rd_data_o  (rd_data[j]),
            .rd_busy_o  (rd_busy[j])
        );
    end

    assign bus.rPorts = rd_data;
    assign bus.rBusy  = rd_busy;

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Testbench for regfile_mp_sb. Two instances share one stimulus stream:
// dut 0 with write-to-read bypass, dut 1 without. Stimulus pushes expected
// observations into a queue; a monitor drains and compares them on the
// falling edge, after inputs applied just past the rising edge have settled.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int AW  = 5;

    typedef enum int {K_READY, K_DATA, K_BUSY} kind_t;

    typedef struct {
        string       name;
        int          dut;
        kind_t       kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NWP-1:0]         we;
    logic [NWP-1:0][AW-1:0] w_addrs;
    logic [NWP-1:0][DW-1:0] w_data;
    logic [NRP-1:0][AW-1:0] r_addrs;
    logic                   issue_valid;
    logic [AW-1:0]          issue_addr;

    regfile_mp_sb_if #(.N_REGS(NR), .DATA_WIDTH(DW), .N_READ_PORTS(NRP),
                       .N_WRITE_PORTS(NWP), .ADDR_WIDTH(AW)) bus_byp ();
    regfile_mp_sb_if #(.N_REGS(NR), .DATA_WIDTH(DW), .N_READ_PORTS(NRP),
                       .N_WRITE_PORTS(NWP), .ADDR_WIDTH(AW)) bus_nob ();

    assign bus_byp.we = we;           assign bus_nob.we = we;
    assign bus_byp.wAddrs = w_addrs;  assign bus_nob.wAddrs = w_addrs;
    assign bus_byp.wPorts = w_data;   assign bus_nob.wPorts = w_data;
    assign bus_byp.rAddrs = r_addrs;  assign bus_nob.rAddrs = r_addrs;
    assign bus_byp.issueValid = issue_valid;
    assign bus_nob.issueValid = issue_valid;
    assign bus_byp.issueAddr = issue_addr;
    assign bus_nob.issueAddr = issue_addr;

    regfile_mp_sb #(.N_REGS(NR), .DATA_WIDTH(DW), .N_READ_PORTS(NRP),
                    .N_WRITE_PORTS(NWP), .ADDR_WIDTH(AW), .BYPASS(1), .ZERO_REG(1))
        dut_byp (.clk(clk), .rst(rst), .bus(bus_byp));

    regfile_mp_sb #(.N_REGS(NR), .DATA_WIDTH(DW), .N_READ_PORTS(NRP),
                    .N_WRITE_PORTS(NWP), .ADDR_WIDTH(AW), .BYPASS(0), .ZERO_REG(1))
        dut_nob (.clk(clk), .rst(rst), .bus(bus_nob));

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic push(input string name, input int dut, input kind_t kind,
                        input int idx, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.dut = dut; e.kind = kind; e.idx = idx; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_rd(input string name, input int dut, input int port,
                           input logic [31:0] data, input logic busy);
        push(name, dut, K_DATA, port, data);
        push(name, dut, K_BUSY, port, {31'd0, busy});
    endtask

    task automatic push_rd_both(input string name, input int port,
                                input logic [31:0] data, input logic busy);
        push_rd(name, 0, port, data, busy);
        push_rd(name, 1, port, data, busy);
    endtask

    task automatic push_ready_both(input string name, input logic rdy);
        push(name, 0, K_READY, 0, {31'd0, rdy});
        push(name, 1, K_READY, 0, {31'd0, rdy});
    endtask

    function automatic logic [31:0] observe(input int dut, input kind_t kind, input int idx);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_READY: v = (dut == 0) ? 32'(bus_byp.ready) : 32'(bus_nob.ready);
            K_DATA:  v = (dut == 0) ? bus_byp.rPorts[idx] : bus_nob.rPorts[idx];
            K_BUSY:  v = (dut == 0) ? 32'(bus_byp.rBusy[idx]) : 32'(bus_nob.rBusy[idx]);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check(input exp_t e, input logic [31:0] act);
        string what;
        n_cmp++;
        if (act !== e.exp) begin
            n_fail++;
            what = (e.kind == K_READY) ? "ready" : (e.kind == K_DATA) ? "rPorts" : "rBusy";
            $display("FAIL %s: dut%0d %s[%0d] got 0x%08h, required 0x%08h",
                     e.name, e.dut, what, e.idx, act, e.exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check(e, observe(e.dut, e.kind, e.idx));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = '0;
        issue_valid = 1'b0;
    endtask

    // Runs the 32-cycle init walk right after rst has been sampled high,
    // driving traffic that must be ignored; ends with ready asserted.
    task automatic init_walk(input string name);
        we          = '1;
        w_addrs     = {AW'(5), AW'(5)};
        w_data      = {32'h0000_DEAD, 32'h0000_DEAD};
        issue_valid = 1'b1;
        issue_addr  = AW'(5);
        for (int k = 0; k < NR; k++) begin
            r_addrs = {AW'(k), AW'(5)};
            push_ready_both({name, " ready low"}, 1'b0);
            push_rd_both({name, " init read p0"}, 0, 32'h0, 1'b0);
            push_rd_both({name, " init read p1"}, 1, 32'h0, 1'b0);
            cycle();
        end
        idle();
        r_addrs = {AW'(1), AW'(5)};
        push_ready_both({name, " ready high"}, 1'b1);
        push_rd_both({name, " r5 after init"}, 0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return 32'hC0DE_0000 | 32'(i * 17 + 1);
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; we = '0; w_addrs = '0; w_data = '0; r_addrs = '0;
        issue_valid = 1'b0; issue_addr = '0;
        cycle();
        rst = 1'b0;
        init_walk("reset");

        // Basic write/read, write to r0 dropped.
        cycle();
        we = 2'b11;
        w_addrs = {AW'(0), AW'(3)};
        w_data  = {32'hFFFF_FFFF, 32'h1234_5678};
        r_addrs = {AW'(0), AW'(3)};
        push_rd("wr r3 fwd", 0, 0, 32'h1234_5678, 1'b0);
        push_rd("wr r3 nofwd", 1, 0, 32'h0, 1'b0);
        push_rd_both("wr r0 same cycle", 1, 32'h0, 1'b0);
        cycle();
        idle();
        push_rd_both("r3 next cycle", 0, 32'h1234_5678, 1'b0);
        push_rd_both("r0 reads zero", 1, 32'h0, 1'b0);

        // Conflict: both ports to r7, highest port wins.
        cycle();
        we = 2'b11;
        w_addrs = {AW'(7), AW'(7)};
        w_data  = {32'h0000_BBBB, 32'h0000_AAAA};
        r_addrs = {AW'(3), AW'(7)};
        push_rd("conflict fwd", 0, 0, 32'h0000_BBBB, 1'b0);
        push_rd("conflict nofwd", 1, 0, 32'h0, 1'b0);
        push_rd_both("unrelated read", 1, 32'h1234_5678, 1'b0);
        cycle();
        idle();
        push_rd_both("conflict stored", 0, 32'h0000_BBBB, 1'b0);

        // Two ports, distinct addresses, both land.
        cycle();
        we = 2'b11;
        w_addrs = {AW'(11), AW'(10)};
        w_data  = {32'h0000_00B1, 32'h0000_00A0};
        cycle();
        idle();
        r_addrs = {AW'(11), AW'(10)};
        push_rd_both("dual write p0", 0, 32'h0000_00A0, 1'b0);
        push_rd_both("dual write p1", 1, 32'h0000_00B1, 1'b0);

        // Bypass on/off: r9 holds 0x11, overwrite with 0x55 while reading.
        cycle();
        we = 2'b01; w_addrs[0] = AW'(9); w_data[0] = 32'h11;
        cycle();
        we = 2'b01; w_addrs[0] = AW'(9); w_data[0] = 32'h55;
        r_addrs[0] = AW'(9);
        push_rd("bypass on", 0, 0, 32'h55, 1'b0);
        push_rd("bypass off old", 1, 0, 32'h11, 1'b0);
        cycle();
        idle();
        push_rd_both("bypass off new", 0, 32'h55, 1'b0);

        // Scoreboard.
        cycle();
        issue_valid = 1'b1; issue_addr = AW'(4);
        r_addrs[1] = AW'(4);
        push_rd_both("issue same cycle", 1, 32'h0, 1'b0);
        cycle();
        idle();
        push_rd_both("busy after issue", 1, 32'h0, 1'b1);
        cycle();
        we = 2'b01; w_addrs[0] = AW'(4); w_data[0] = 32'h44;
        push_rd("wb fwd clears busy", 0, 1, 32'h44, 1'b0);
        push_rd("wb nofwd busy", 1, 1, 32'h0, 1'b1);
        cycle();
        idle();
        push_rd_both("busy cleared", 1, 32'h44, 1'b0);
        cycle();
        issue_valid = 1'b1; issue_addr = AW'(4);
        we = 2'b01; w_addrs[0] = AW'(4); w_data[0] = 32'h45;
        push_rd("set+clear fwd", 0, 1, 32'h45, 1'b0);
        push_rd("set+clear nofwd", 1, 1, 32'h44, 1'b0);
        cycle();
        idle();
        push_rd_both("set wins", 1, 32'h45, 1'b1);
        cycle();
        issue_valid = 1'b1; issue_addr = AW'(0);
        r_addrs[1] = AW'(0);
        cycle();
        idle();
        push_rd_both("issue r0 ignored", 1, 32'h0, 1'b0);

        // Mid-operation reset: fill r1..r31, mark r2 busy, then reset.
        for (int i = 1; i <= NR - 1; i += 2) begin
            cycle();
            we[0] = 1'b1; w_addrs[0] = AW'(i); w_data[0] = fill_val(i);
            we[1] = (i + 1 <= NR - 1);
            w_addrs[1] = AW'(i + 1); w_data[1] = fill_val(i + 1);
        end
        cycle();
        idle();
        issue_valid = 1'b1; issue_addr = AW'(2);
        cycle();
        idle();
        r_addrs = {AW'(2), AW'(31)};
        push_rd_both("fill r31", 0, fill_val(31), 1'b0);
        push_rd_both("fill r2 busy", 1, fill_val(2), 1'b1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        init_walk("midop reset");
        for (int k = 0; k < NR / 2; k++) begin
            cycle();
            r_addrs = {AW'(2 * k + 1), AW'(2 * k)};
            push_rd_both("cleared p0", 0, 32'h0, 1'b0);
            push_rd_both("cleared p1", 1, 32'h0, 1'b0);
        end

        cycle();
        cycle();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_regfile_mp_sb

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Next-generation multi-ported register file for the RISC-V core.
- N independent read and write ports, each write port with its own enable.
- Deterministic write-conflict priority, optional write-to-read bypass, configurable hardwired zero register.
- Per-register pending-write scoreboard for hazard detection.
- Clears its storage with a sequential init walk after reset, so no wide reset fan-out; sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- N_REGS, 32, number of architectural registers (≥2).
- DATA_WIDTH, 32, register width in bits.
- N_READ_PORTS, 2, number of combinational read ports.
- N_WRITE_PORTS, 2, number of write ports.
- ADDR_WIDTH, $clog2(N_REGS), register address width.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and scoreboard sets.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset (sampled on posedge clk).
- ready  out  1  high when init walk is complete and the file accepts traffic.
- we  in  [N_WRITE_PORTS]  per-port write enable.
- wAddrs  in  ADDR_WIDTH x N_WRITE_PORTS  write addresses.
- wPorts  in  DATA_WIDTH x N_WRITE_PORTS  write data.
- rAddrs  in  ADDR_WIDTH x N_READ_PORTS  read addresses.
- rPorts  out  DATA_WIDTH x N_READ_PORTS  read data, combinational.
- rBusy  out  [N_READ_PORTS]  read register has a pending write.
- issueValid  in  1  mark issueAddr as pending (scoreboard set).
- issueAddr  in  ADDR_WIDTH  destination register being issued.

Behaviour:
- State machine: RF_INIT, RF_READY.
- Reset:
  - rst high at a posedge → state=RF_INIT, initCnt=0, all busy bits=0, ready=0.
  - rst asserted at any time, including mid-init or mid-operation, restarts the walk.
- RF_INIT:
  - Each cycle regs[initCnt]<=0, initCnt++.
  - After the cycle writing index N_REGS-1, state=RF_READY.
  - ready rises on the first cycle after rst deasserts + N_REGS cycles (32 by default).
  - we and issueValid are ignored.
  - rPorts=0 and rBusy=0 regardless of address.
- RF_READY writes:
  - Port i writes regs[wAddrs[i]]<=wPorts[i] when we[i]=1.
  - Suppressed when ZERO_REG=1 and the address is 0.
  - Suppressed when the address is ≥N_REGS.
  - Several enabled ports hitting the same address in one cycle: the highest port index wins; the others are dropped silently.
- Scoreboard:
  - An enabled, non-suppressed write to r clears busy[r].
  - issueValid sets busy[issueAddr]; with ZERO_REG=1 and address 0, or address ≥N_REGS, it is ignored.
  - Set and clear of the same register in the same cycle: set wins, busy stays 1.
  - busy updates are visible on rBusy the next cycle.
- Reads (combinational, zero latency), priority per port j:
  1. ZERO_REG and rAddrs[j]==0, or address ≥N_REGS → 0.
  2. Otherwise, BYPASS=1 and some enabled write targets rAddrs[j] this cycle → that write's data, highest port index.
  3. Otherwise → regs[rAddrs[j]].
  - With BYPASS=0, written data is visible the cycle after the write.
- rBusy[j]:
  - = busy[rAddrs[j]] AND NOT (BYPASS AND bypass hit on port j).
  - Forced 0 when case 1 above applies.
- No reset values on regs other than via the init walk; outputs are defined (0) from the first cycle rst is sampled high.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic {RF_INIT, RF_READY} rf_state_t.
  - Default constants RF_N_REGS=32, RF_DATA_WIDTH=32.
- Width-dependent types stay local to the module.
- One sub-module, regfile_fwd_mux: per-read-port priority/bypass select (zero check, highest-index write match, array fallback), instantiated N_READ_PORTS times in a generate loop.

Test Plan:
- Reset/init: pulse rst 1 cycle, then drive we=all 1 to addr 5 with 0xDEAD during init → ready low for exactly 32 cycles; rPorts=0; after ready, read addr 5 = 0x00000000.
- Basic write/read: write 0x12345678 to r3 on port 0; read r3 next cycle → 0x12345678; write 0xFFFFFFFF to r0 → r0 reads 0.
- Conflict: port0 writes 0xAAAA and port1 writes 0xBBBB to r7 in the same cycle → r7=0xBBBB next cycle; same-cycle bypass read of r7 = 0xBBBB.
- Bypass off (BYPASS=0): write 0x55 to r9 while reading r9 holding 0x11 → read 0x11 that cycle, 0x55 next cycle.
- Scoreboard: issueValid to r4 → rBusy=1 next cycle; writeback to r4 with a read of r4 → rBusy=0 and data forwarded same cycle; simultaneous issue and write to r4 → busy stays 1.
- Mid-operation reset: fill r1..r31 with nonzero values and set busy on r2, assert rst → ready=0, rBusy=0, all reads 0 during init; after 32 cycles all registers read 0.
